// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Purpose : shared constants and types for the VGA raster timing generator.
//           - 640x480@60 default timing constants (used as parameter defaults)
//           - H_TOTAL / V_TOTAL for the default raster (800 x 525)
//           - phase_e: the porch/sync phase enum shared by the H and V FSMs
//           - next_phase(): one step of a phase FSM, given the next position
// Ports   : none (package)
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {
    PH_ACT  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_e;

  // Phase transitions are decided on the position the counter is about to
  // take, so the registered phase lines up with the registered position.
  // A next position of 0 can only come from the wrap, which closes BP.
  function automatic phase_e next_phase(input phase_e      cur,
                                        input logic [10:0] pos_nxt,
                                        input logic [10:0] fp_start,
                                        input logic [10:0] sync_start,
                                        input logic [10:0] bp_start);
    phase_e nxt;
    nxt = cur;
    case (cur)
      PH_ACT:  if (pos_nxt == fp_start)   nxt = PH_FP;
      PH_FP:   if (pos_nxt == sync_start) nxt = PH_SYNC;
      PH_SYNC: if (pos_nxt == bp_start)   nxt = PH_BP;
      PH_BP:   if (pos_nxt == 11'd0)      nxt = PH_ACT;
      default: nxt = PH_ACT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Purpose : raster timing bundle produced by vga_timing_gen.
//   pix_tick  one-clk pulse per pixel period
//   pix_inc   pix_tick & video_on (feeds frame_counter.inc)
//   sync_clr  one-clk pulse per frame at vsync entry (feeds frame_counter.sync_clr)
//   hsync     horizontal sync pin level
//   vsync     vertical sync pin level
//   video_on  high inside the active window
//   hpos      raster column
//   vpos      raster line
//   frame_num 16-bit frame count, only when VGA_FRAME_COUNT_EN is defined
// Modports: master (generator side, drives), slave (consumer side, reads).
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
  logic        pix_tick;
  logic        pix_inc;
  logic        sync_clr;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [10:0] hpos;
  logic [10:0] vpos;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_num;
`endif

  modport master (
    output pix_tick, pix_inc, sync_clr, hsync, vsync, video_on, hpos, vpos
`ifdef VGA_FRAME_COUNT_EN
    , output frame_num
`endif
  );

  modport slave (
    input pix_tick, pix_inc, sync_clr, hsync, vsync, video_on, hpos, vpos
`ifdef VGA_FRAME_COUNT_EN
    , input frame_num
`endif
  );
endinterface

// File: rtl/vga_tick_div.sv
// ---------------------------------------------------------------------------
// vga_tick_div
// Purpose : clock-enable divider. Counts 0..CLK_DIV-1 while enable is high
//           and raises pix_tick for the clk where the count is CLK_DIV-1.
//           With CLK_DIV=1 pix_tick follows enable.
// Ports   : clk (in), reset (in, async active-high), enable (in),
//           pix_tick (out, combinational, 0 whenever enable is low)
// ---------------------------------------------------------------------------
module vga_tick_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic pix_tick
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  always_comb begin
    div_d = div_q;
    if (enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

  assign pix_tick = enable & (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Purpose : raster timing source. Divides clk into a pixel tick and walks the
//           full H_TOTAL x V_TOTAL raster, driving hsync/vsync, video_on,
//           pix_inc (one clk per active pixel) and sync_clr (one per frame).
// Ports   : clk    (in)  system clock
//           reset  (in)  asynchronous, active-high
//           enable (in)  run; when low every piece of state holds
//           vga    (vga_timing_gen_if.master) timing outputs
// Config  : define VGA_FRAME_COUNT_EN to add the 16-bit frame_num counter.
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  vga_timing_gen_if.master  vga
);

  localparam logic [10:0] H_FP_START   = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_BP_START   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST       = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_FP_START   = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_BP_START   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST       = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic        pix_tick;
  logic        h_wrap;
  logic        v_wrap;
  logic [10:0] hpos_q, hpos_d;
  logic [10:0] vpos_q, vpos_d;
  phase_e      h_phase_q, h_phase_d;
  phase_e      v_phase_q, v_phase_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        video_on_q, video_on_d;

  vga_tick_div #(.CLK_DIV(CLK_DIV)) u_tick_div (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .pix_tick (pix_tick)
  );

  // Sync and video_on are computed from the next phase so the registered
  // levels change on the same edge as hpos/vpos (no position-to-sync skew).
  always_comb begin
    hpos_d    = hpos_q;
    vpos_d    = vpos_q;
    h_phase_d = h_phase_q;
    v_phase_d = v_phase_q;
    h_wrap    = (hpos_q == H_LAST);
    v_wrap    = (vpos_q == V_LAST);
    if (pix_tick) begin
      hpos_d    = h_wrap ? 11'd0 : hpos_q + 11'd1;
      h_phase_d = next_phase(h_phase_q, hpos_d, H_FP_START, H_SYNC_START, H_BP_START);
      if (h_wrap) begin
        vpos_d    = v_wrap ? 11'd0 : vpos_q + 11'd1;
        v_phase_d = next_phase(v_phase_q, vpos_d, V_FP_START, V_SYNC_START, V_BP_START);
      end
    end
    hsync_d    = (h_phase_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    vsync_d    = (v_phase_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    video_on_d = (h_phase_d == PH_ACT) && (v_phase_d == PH_ACT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos_q     <= '0;
      vpos_q     <= '0;
      h_phase_q  <= PH_ACT;
      v_phase_q  <= PH_ACT;
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
      video_on_q <= 1'b1;
    end else begin
      hpos_q     <= hpos_d;
      vpos_q     <= vpos_d;
      h_phase_q  <= h_phase_d;
      v_phase_q  <= v_phase_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_num_q, frame_num_d;

  // Counts the (H_LAST, V_LAST) -> (0, 0) wrap; 16-bit rollover is natural.
  always_comb begin
    frame_num_d = frame_num_q;
    if (pix_tick && h_wrap && v_wrap) frame_num_d = frame_num_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_num_q <= '0;
    else       frame_num_q <= frame_num_d;
  end

  assign vga.frame_num = frame_num_q;
`endif

  assign vga.pix_tick = pix_tick;
  assign vga.pix_inc  = pix_tick & video_on_q;
  // Tick at (0, first vsync line): sits outside the active window, so it
  // can never coincide with pix_inc.
  assign vga.sync_clr = pix_tick & (hpos_q == 11'd0) & (vpos_q == V_SYNC_START);
  assign vga.hsync    = hsync_q;
  assign vga.vsync    = vsync_q;
  assign vga.video_on = video_on_q;
  assign vga.hpos     = hpos_q;
  assign vga.vpos     = vpos_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Purpose : self-checking bench for vga_timing_gen on a reduced raster.
//           Expected values come from an arithmetic model: the number of
//           enabled clks since reset gives the pixel index, and the pixel
//           index gives position, sync levels, video window and pulses.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned H_ACTIVE = 20;
  localparam int unsigned H_FP     = 3;
  localparam int unsigned H_SYNC   = 5;
  localparam int unsigned H_BP     = 4;
  localparam int unsigned V_ACTIVE = 12;
  localparam int unsigned V_FP     = 2;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 3;
  localparam bit          SYNC_POL = 1'b0;
  localparam int unsigned HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned FRAME    = HT * VT;

  logic clk = 1'b0;
  logic reset;
  logic enable;

  vga_timing_gen_if vga_bus ();

  vga_timing_gen #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .vga    (vga_bus.master)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_en    = 0;   // enabled clk edges since reset release
  int unsigned inc_cnt = 0;
  int unsigned clr_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clk: apply enable at the falling edge, compare just after, then let
  // the rising edge happen and advance the model.
  task automatic step(input logic en);
    int unsigned pix, p, h, v;
    logic tick_e, vid_e;
    @(negedge clk);
    enable = en;
    #1;
    pix    = n_en / CLK_DIV;
    p      = pix % FRAME;
    h      = p % HT;
    v      = p / HT;
    tick_e = en && ((n_en % CLK_DIV) == CLK_DIV - 1);
    vid_e  = (h < H_ACTIVE) && (v < V_ACTIVE);
    check_val("hpos",     vga_bus.hpos, h);
    check_val("vpos",     vga_bus.vpos, v);
    check_val("pix_tick", vga_bus.pix_tick, tick_e);
    check_val("video_on", vga_bus.video_on, vid_e);
    check_val("pix_inc",  vga_bus.pix_inc, tick_e && vid_e);
    check_val("sync_clr", vga_bus.sync_clr, tick_e && h == 0 && v == V_ACTIVE + V_FP);
    check_val("hsync",    vga_bus.hsync,
              (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL : !SYNC_POL);
    check_val("vsync",    vga_bus.vsync,
              (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL : !SYNC_POL);
`ifdef VGA_FRAME_COUNT_EN
    check_val("frame_num", vga_bus.frame_num, (pix / FRAME) % 65536);
`endif
    if (vga_bus.pix_inc)  inc_cnt++;
    if (vga_bus.sync_clr) clr_cnt++;
    @(posedge clk);
    if (en) n_en++;
  endtask

  // Assert reset between edges and check the asynchronous return to reset values.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_val({tag, "_hpos"},     vga_bus.hpos, 0);
    check_val({tag, "_vpos"},     vga_bus.vpos, 0);
    check_val({tag, "_hsync"},    vga_bus.hsync, !SYNC_POL);
    check_val({tag, "_vsync"},    vga_bus.vsync, !SYNC_POL);
    check_val({tag, "_video_on"}, vga_bus.video_on, 1);
    check_val({tag, "_pix_tick"}, vga_bus.pix_tick, 0);
    check_val({tag, "_sync_clr"}, vga_bus.sync_clr, 0);
`ifdef VGA_FRAME_COUNT_EN
    check_val({tag, "_frame_num"}, vga_bus.frame_num, 0);
`endif
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b0;
    n_en   = 0;
  endtask

  initial begin
    int unsigned guard;
    reset  = 1'b0;
    enable = 1'b0;

    // Power-up reset.
    do_reset("rst0");

    // Exactly one frame fully enabled: count the pulses.
    inc_cnt = 0;
    clr_cnt = 0;
    for (int i = 0; i < int'(FRAME * CLK_DIV); i++) step(1'b1);
    check_val("frame_pix_inc", inc_cnt, H_ACTIVE * V_ACTIVE);
    check_val("frame_sync_clr", clr_cnt, 1);

    // Pause mid-line at the start of pixel 10, hold for 37 clks, resume.
    guard = 0;
    while (!(((n_en / CLK_DIV) % HT) == 10 && (n_en % CLK_DIV) == 0) && guard < 4 * FRAME * CLK_DIV) begin
      step(1'b1);
      guard++;
    end
    check_val("pause_reached", (guard < 4 * FRAME * CLK_DIV), 1);
    for (int i = 0; i < 37; i++) step(1'b0);
    for (int i = 0; i < 2 * int'(CLK_DIV); i++) step(1'b1);

    // Random enable pattern across several frames.
    for (int i = 0; i < 3000; i++) step($urandom_range(0, 9) != 0);

    // Reset in the back porch of a mid-frame line, then random again.
    guard = 0;
    while (!(((n_en / CLK_DIV) % HT) == H_ACTIVE + H_FP + H_SYNC + 1 &&
             ((n_en / CLK_DIV) % FRAME) / HT == V_ACTIVE / 2) && guard < 4 * FRAME * CLK_DIV) begin
      step(1'b1);
      guard++;
    end
    check_val("midline_reached", (guard < 4 * FRAME * CLK_DIV), 1);
    do_reset("rst1");
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 7) != 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
